mips_mc_control: RTL

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_mc_control.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences datapath control and counts retired instructions.
// Optional build macro ILLEGAL_TRAP_EN: unsupported instructions lock the FSM in TRAP instead of retiring as a NOP.
module mips_mc_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_BRANCH    = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t S_UNSUP = S_TRAP;
`else
  localparam state_t S_UNSUP = S_FETCH;
`endif

  state_t      state_q, state_d;
  logic [31:0] instr_retired_q, instr_retired_d;
  logic [3:0]  r_alu_ctrl;
  logic        funct_ok;
  logic        retire;
  logic        pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_FETCH;
      instr_retired_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      instr_retired_q <= instr_retired_d;
    end
  end

  always_comb begin
    funct_ok   = 1'b1;
    r_alu_ctrl = 4'b0000;
    case (funct)
      6'b100100: r_alu_ctrl = ALU_AND;
      6'b100101: r_alu_ctrl = ALU_OR;
      6'b100000: r_alu_ctrl = ALU_ADD;
      6'b100010: r_alu_ctrl = ALU_SUB;
      6'b101010: r_alu_ctrl = ALU_SLT;
      6'b000000: r_alu_ctrl = ALU_SLL;
      6'b000010: r_alu_ctrl = ALU_SRL;
      default:   funct_ok   = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_I_EXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_UNSUP;
        endcase
      end
      S_R_EXEC:    state_d = funct_ok ? S_R_WB : S_UNSUP;
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_READ;
        else if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                      state_d = S_UNSUP;
      end
      S_MEM_READ:  state_d = S_MEM_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_R_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_I_WB, S_JUMP:
                   state_d = S_FETCH;
      S_TRAP:      state_d = S_UNSUP;
      default:     state_d = S_FETCH;
    endcase
  end

  // Only the final state of a completed instruction retires it; NOP returns to FETCH never do.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_R_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_I_WB, S_JUMP: retire = 1'b1;
      default: retire = 1'b0;
    endcase
    instr_retired_d = retire ? instr_retired_q + 32'd1 : instr_retired_q;
  end

  always_comb begin
    alu_ctrl      = 4'b0000;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    iord          = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b01;
        alu_ctrl     = ALU_ADD;
        pc_write_raw = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = r_alu_ctrl;
      end
      S_R_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_read_raw = 1'b1;
        iord         = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_raw = 1'b1;
        iord          = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_ctrl     = ALU_SUB;
        pc_src       = 2'b01;
        pc_write_raw = zero;
      end
      S_I_WB:  reg_write_raw = 1'b1;
      S_JUMP: begin
        pc_src       = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are masked directly by rst_n so nothing is written while reset is held.
  assign pc_write      = pc_write_raw  & rst_n;
  assign ir_write      = ir_write_raw  & rst_n;
  assign mem_read      = mem_read_raw  & rst_n;
  assign mem_write     = mem_write_raw & rst_n;
  assign reg_write     = reg_write_raw & rst_n;
  assign state         = state_q;
  assign illegal       = (state_q == S_TRAP);
  assign instr_retired = instr_retired_q;

endmodule
